// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: replays a 32-step on/off pattern onto a single-bit
// PIO through an Avalon-MM write-only master, one step every PERIOD cycles.
// A small CSR slave lets the host program the pattern, period and length.
//
// Master handshake: a transfer is presented while m_chipselect=1 and
// m_write_n=0. Address and data stay frozen while m_waitrequest=1. The
// transfer completes on the first such cycle with m_waitrequest=0, and is
// never withdrawn early.
module led_pattern_sequencer #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    output logic [1:0]          m_address,
    output logic                m_chipselect,
    output logic                m_write_n,
    output logic [31:0]         m_writedata,
    input  logic                m_waitrequest
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_WAIT  = 2'd2,
        S_OFF   = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic                  en_q, en_d;
    logic                  oneshot_q, oneshot_d;
    logic [4:0]            last_q, last_d;
    logic [PERIOD_W-1:0]   period_q, period_d;
    logic [31:0]           pattern_q, pattern_d;
    logic                  done_q, done_d;
    logic [4:0]            step_q, step_d;
    logic [PERIOD_W-1:0]   cnt_q, cnt_d;
    logic                  led_q, led_d;

    logic                  csr_wr;
    logic                  hw_set_done;
    logic                  hw_clr_en;
    logic [PERIOD_W-1:0]   period_m1;
    logic [4:0]            nxt_step;

    assign csr_wr    = chipselect & ~write_n;
    // A programmed period of 0 behaves like 1.
    assign period_m1 = (period_q == '0) ? '0 : period_q - PERIOD_W'(1);
    // Stepping past LAST relies on the natural 5-bit wrap, so a LAST lowered
    // below the current step is reached again only after 31 -> 0.
    assign nxt_step  = (step_q == last_q) ? 5'd0 : step_q + 5'd1;

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            cnt_q   <= '0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
        end
    end

    // Next-state logic; the LED bit is latched on entry to WRITE so the data
    // stays stable through a stall even if PATTERN is rewritten meanwhile.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        cnt_d       = cnt_q;
        led_d       = led_q;
        hw_set_done = 1'b0;
        hw_clr_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en_q) begin
                    state_d = S_WRITE;
                    step_d  = 5'd0;
                    led_d   = pattern_q[0];
                end
            end
            S_WRITE: begin
                if (!m_waitrequest) begin
                    cnt_d   = '0;
                    state_d = en_q ? S_WAIT : S_OFF;
                end
            end
            S_WAIT: begin
                if (!en_q) begin
                    state_d = S_OFF;
                end else if (cnt_q == period_m1) begin
                    if ((step_q == last_q) && oneshot_q) begin
                        hw_set_done = 1'b1;
                        hw_clr_en   = 1'b1;
                        state_d     = S_OFF;
                    end else begin
                        step_d  = nxt_step;
                        led_d   = pattern_q[nxt_step];
                        state_d = S_WRITE;
                    end
                end else begin
                    cnt_d = cnt_q + PERIOD_W'(1);
                end
            end
            S_OFF: begin
                if (!m_waitrequest) begin
                    state_d = S_IDLE;
                    step_d  = 5'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // CSR register file.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q      <= 1'b0;
            oneshot_q <= 1'b0;
            last_q    <= '0;
            period_q  <= '0;
            pattern_q <= '0;
            done_q    <= 1'b0;
        end else begin
            en_q      <= en_d;
            oneshot_q <= oneshot_d;
            last_q    <= last_d;
            period_q  <= period_d;
            pattern_q <= pattern_d;
            done_q    <= done_d;
        end
    end

    // CSR updates: host writes first, then hardware events override them.
    always_comb begin
        en_d      = en_q;
        oneshot_d = oneshot_q;
        last_d    = last_q;
        period_d  = period_q;
        pattern_d = pattern_q;
        done_d    = done_q;
        if (csr_wr) begin
            case (address)
                2'd0: begin
                    en_d      = writedata[0];
                    oneshot_d = writedata[1];
                    last_d    = writedata[12:8];
                end
                2'd1:    period_d  = writedata[PERIOD_W-1:0];
                2'd2:    pattern_d = writedata;
                default: if (writedata[1]) done_d = 1'b0;
            endcase
        end
        if (hw_clr_en) en_d = 1'b0;
        if (hw_set_done) done_d = 1'b1;
    end

    // Zero-wait-state CSR read mux; reflects register contents before any
    // write landing on the same edge.
    always_comb begin
        readdata = '0;
        case (address)
            2'd0: begin
                readdata[0]    = en_q;
                readdata[1]    = oneshot_q;
                readdata[12:8] = last_q;
            end
            2'd1:    readdata[PERIOD_W-1:0] = period_q;
            2'd2:    readdata = pattern_q;
            default: begin
                readdata[0]    = (state_q != S_IDLE);
                readdata[1]    = done_q;
                readdata[12:8] = step_q;
            end
        endcase
    end

    // Master outputs decode straight from state so reset drops them at once.
    always_comb begin
        m_address    = 2'd0;
        m_chipselect = (state_q == S_WRITE) || (state_q == S_OFF);
        m_write_n    = ~m_chipselect;
        m_writedata  = {31'b0, (state_q == S_WRITE) & led_q};
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: CSR vector table, scoreboard of expected
// LED transfers (data, spacing, duration) and hand-written corner sequences.
module tb_led_pattern_sequencer;

    localparam int W = 48;   // {len[7:0], gap[7:0], data[31:0]}

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic        m_waitrequest;

    led_pattern_sequencer #(.PERIOD_W(24)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .address       (address),
        .chipselect    (chipselect),
        .write_n       (write_n),
        .writedata     (writedata),
        .readdata      (readdata),
        .m_address     (m_address),
        .m_chipselect  (m_chipselect),
        .m_write_n     (m_write_n),
        .m_writedata   (m_writedata),
        .m_waitrequest (m_waitrequest)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rexp;
    } csr_vec_t;
    csr_vec_t vecs[8];

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ent(input int len, input int gap, input logic [31:0] d);
        return {8'(len), 8'(gap), d};
    endfunction

    // Transfer monitor: pops one expectation per transfer start, checks data,
    // spacing from the previous start, stability while stalled, and duration.
    int           cyc = 0;
    int           last_start = 0;
    logic         in_flight = 1'b0;
    int           cur_len = 0;
    logic [W-1:0] cur_e = '0;

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            in_flight = 1'b0;
        end else begin
            if (in_flight) begin
                cur_len++;
                check("xfer_hold_strobes", {46'b0, m_chipselect, m_write_n}, 48'b10);
                check("xfer_hold_data", {16'b0, m_writedata}, {16'b0, cur_e[31:0]});
            end else if (m_chipselect) begin
                check("xfer_expected", {47'b0, exp_q.size() != 0}, 48'd1);
                cur_e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                check("xfer_strobes", {44'b0, m_address, m_chipselect, m_write_n}, 48'b0010);
                check("xfer_data", {16'b0, m_writedata}, {16'b0, cur_e[31:0]});
                if (cur_e[39:32] != 8'd0)
                    check("xfer_gap", 48'(cyc - last_start), {40'b0, cur_e[39:32]});
                last_start = cyc;
                cur_len    = 1;
                in_flight  = 1'b1;
            end
            if (in_flight && !m_waitrequest) begin
                if (cur_e[47:40] != 8'd0)
                    check("xfer_len", 48'(cur_len), {40'b0, cur_e[47:40]});
                in_flight = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk);
        #1 address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk);
        #1 chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
        @(posedge clk);
        #1 address = a; chipselect = 1'b1; write_n = 1'b1;
        #2 d = readdata;
        chipselect = 1'b0;
    endtask

    task automatic wait_pops(input int n);
        int k = 0;
        while (exp_q.size() > n && k < 1000) begin
            @(posedge clk);
            k++;
        end
        check("wait_pops_timeout", {47'b0, k < 1000}, 48'd1);
    endtask

    task automatic wait_cs();
        int k = 0;
        @(negedge clk);
        while (!m_chipselect && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("wait_cs_timeout", {47'b0, k < 200}, 48'd1);
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((exp_q.size() != 0 || in_flight || m_chipselect) && k < 1000) begin
            @(posedge clk);
            k++;
        end
        check("drain_timeout", {47'b0, k < 1000}, 48'd1);
        repeat (2) @(posedge clk);
    endtask

    // ---------------- test sequence ----------------
    logic [31:0] rd;

    initial begin
        chipselect    = 1'b0;
        write_n       = 1'b1;
        address       = 2'd0;
        writedata     = '0;
        m_waitrequest = 1'b0;
        reset_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset state
        for (int a = 0; a < 4; a++) begin
            csr_read(2'(a), rd);
            check($sformatf("reset_csr%0d", a), {16'b0, rd}, 48'd0);
        end
        check("reset_master_strobes", {46'b0, m_chipselect, m_write_n}, 48'b01);
        check("reset_master_data", {16'b0, m_writedata}, 48'd0);

        // CSR write/readback table (EN kept 0)
        vecs[0] = '{2'd0, 32'h0000_1F02, 32'h0000_1F02};
        vecs[1] = '{2'd0, 32'hFFFF_E0FE, 32'h0000_0002};
        vecs[2] = '{2'd1, 32'hFFFF_FFFF, 32'h00FF_FFFF};
        vecs[3] = '{2'd1, 32'h0000_0003, 32'h0000_0003};
        vecs[4] = '{2'd2, 32'hA5A5_5A5A, 32'hA5A5_5A5A};
        vecs[5] = '{2'd2, 32'h0000_0005, 32'h0000_0005};
        vecs[6] = '{2'd3, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[7] = '{2'd0, 32'h0000_0000, 32'h0000_0000};
        for (int i = 0; i < 8; i++) begin
            csr_write(vecs[i].addr, vecs[i].wdata);
            csr_read(vecs[i].addr, rd);
            check($sformatf("csr_vec%0d", i), {16'b0, rd}, {16'b0, vecs[i].rexp});
        end

        // Looping playback, PATTERN=5 LAST=2 PERIOD=3, then disable in WAIT
        exp_q.push_back(ent(1, 0, 1));
        exp_q.push_back(ent(1, 4, 0));
        exp_q.push_back(ent(1, 4, 1));
        exp_q.push_back(ent(1, 4, 1));
        exp_q.push_back(ent(1, 4, 0));
        exp_q.push_back(ent(1, 4, 1));
        csr_write(2'd0, 32'h0000_0201);
        wait_pops(3);
        csr_read(2'd3, rd);
        check("loop_busy", {47'b0, rd[0]}, 48'd1);
        wait_pops(0);
        exp_q.push_back(ent(1, 0, 0));
        csr_write(2'd0, 32'h0);
        wait_drain();
        csr_read(2'd3, rd);
        check("disable_wait_status", {16'b0, rd}, 48'd0);

        // One-shot playback
        exp_q.push_back(ent(1, 0, 1));
        exp_q.push_back(ent(1, 4, 0));
        exp_q.push_back(ent(1, 4, 1));
        exp_q.push_back(ent(1, 4, 0));
        csr_write(2'd0, 32'h0000_0203);
        wait_drain();
        csr_read(2'd3, rd);
        check("oneshot_status", {16'b0, rd}, 48'h2);
        csr_read(2'd0, rd);
        check("oneshot_control", {16'b0, rd}, 48'h202);
        csr_write(2'd3, 32'h2);
        csr_read(2'd3, rd);
        check("done_clear", {16'b0, rd}, 48'd0);

        // 5-cycle stall on write 2; disable during stalled write 3
        exp_q.push_back(ent(1, 0, 1));
        exp_q.push_back(ent(6, 4, 0));
        exp_q.push_back(ent(6, 9, 1));
        exp_q.push_back(ent(1, 6, 0));
        csr_write(2'd0, 32'h0000_0201);
        wait_pops(3);
        #1 m_waitrequest = 1'b1;
        wait_cs();
        repeat (5) @(posedge clk);
        #1 m_waitrequest = 1'b0;
        repeat (2) @(posedge clk);
        #1 m_waitrequest = 1'b1;
        wait_cs();
        csr_write(2'd0, 32'h0);
        repeat (3) @(posedge clk);
        #1 m_waitrequest = 1'b0;
        wait_drain();
        csr_read(2'd3, rd);
        check("disable_write_status", {16'b0, rd}, 48'd0);

        // PERIOD=0 behaves as 1: transfers 2 cycles apart
        csr_write(2'd1, 32'h0);
        csr_write(2'd2, 32'h2);
        exp_q.push_back(ent(1, 0, 0));
        exp_q.push_back(ent(1, 2, 1));
        exp_q.push_back(ent(1, 2, 0));
        csr_write(2'd0, 32'h0000_0103);
        wait_drain();
        csr_read(2'd3, rd);
        check("period0_status", {16'b0, rd}, 48'h2);
        csr_write(2'd3, 32'h2);

        // Read during write returns the old value
        @(posedge clk);
        #1 address = 2'd2; writedata = 32'h1234_5678; chipselect = 1'b1; write_n = 1'b0;
        #2 check("rdw_old", {16'b0, readdata}, 48'h2);
        @(posedge clk);
        #1 chipselect = 1'b0; write_n = 1'b1;
        csr_read(2'd2, rd);
        check("rdw_new", {16'b0, rd}, 48'h1234_5678);

        // Asynchronous reset in the middle of a stalled write
        csr_write(2'd2, 32'h1);
        csr_write(2'd1, 32'h3);
        m_waitrequest = 1'b1;
        exp_q.push_back(ent(0, 0, 1));
        csr_write(2'd0, 32'h1);
        wait_cs();
        #2 reset_n = 1'b0;
        #1 check("async_reset_strobes", {46'b0, m_chipselect, m_write_n}, 48'b01);
        check("async_reset_data", {16'b0, m_writedata}, 48'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        m_waitrequest = 1'b0;
        for (int a = 0; a < 4; a++) begin
            csr_read(2'(a), rd);
            check($sformatf("post_reset_csr%0d", a), {16'b0, rd}, 48'd0);
        end
        repeat (4) @(posedge clk);

        check("scoreboard_empty", 48'(exp_q.size()), 48'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
